// File: rtl/lsu_stage.sv
// Load/store stage between EXU and WBU.
// It runs one memory operation at a time: IDLE -> ACCESS (held WAIT_CYCLES+1 cycles) -> RESP.
module lsu_stage #(
  parameter int unsigned WAIT_CYCLES = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        in_is_store,
  input  logic [2:0]  in_funct3,
  input  logic [31:0] in_addr,
  input  logic [31:0] in_wdata,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic        out_err,
  output logic        mem_ren,
  output logic [31:0] mem_raddr,
  output logic [31:0] mem_rlen,
  input  logic [31:0] mem_rdata,
  output logic        mem_wen,
  output logic [31:0] mem_waddr,
  output logic [31:0] mem_wdata,
  output logic [7:0]  mem_wmask
);

  typedef enum logic [1:0] {StIdle, StAccess, StResp} state_e;

  state_e      state_q, state_d;
  logic        is_store_q;
  logic [2:0]  funct3_q;
  logic [31:0] addr_q, wdata_q;
  logic [31:0] data_q, data_d;
  logic        err_q, err_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        in_legal;
  logic        last_access;
  logic        accept;
  logic [31:0] load_ext;
  logic [31:0] len_bytes;
  logic [7:0]  wmask;

  assign accept      = (state_q == StIdle) && in_valid;
  assign last_access = (state_q == StAccess) && (cnt_q == 4'd0);

  // Width/sign legality plus natural alignment of the incoming operation.
  always_comb begin
    in_legal = 1'b0;
    case (in_funct3)
      3'b000:  in_legal = 1'b1;
      3'b001:  in_legal = ~in_addr[0];
      3'b010:  in_legal = (in_addr[1:0] == 2'b00);
      3'b100:  in_legal = ~in_is_store;
      3'b101:  in_legal = ~in_is_store & ~in_addr[0];
      default: in_legal = 1'b0;
    endcase
  end

  always_comb begin
    load_ext  = mem_rdata;
    len_bytes = 32'd4;
    wmask     = 8'h0F;
    case (funct3_q)
      3'b000: begin
        load_ext  = {{24{mem_rdata[7]}}, mem_rdata[7:0]};
        len_bytes = 32'd1;
        wmask     = 8'h01;
      end
      3'b001: begin
        load_ext  = {{16{mem_rdata[15]}}, mem_rdata[15:0]};
        len_bytes = 32'd2;
        wmask     = 8'h03;
      end
      3'b100: begin
        load_ext  = {24'd0, mem_rdata[7:0]};
        len_bytes = 32'd1;
        wmask     = 8'h01;
      end
      3'b101: begin
        load_ext  = {16'd0, mem_rdata[15:0]};
        len_bytes = 32'd2;
        wmask     = 8'h03;
      end
      default: begin
        load_ext  = mem_rdata;
        len_bytes = 32'd4;
        wmask     = 8'h0F;
      end
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    err_d   = err_q;
    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          data_d  = 32'd0;
          err_d   = ~in_legal;
          state_d = in_legal ? StAccess : StResp;
          cnt_d   = in_legal ? 4'(WAIT_CYCLES) : 4'd0;
        end
      end
      StAccess: begin
        if (cnt_q == 4'd0) begin
          state_d = StResp;
          if (!is_store_q) data_d = load_ext;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      StResp: begin
        if (out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      cnt_q      <= 4'd0;
      data_q     <= 32'd0;
      err_q      <= 1'b0;
      is_store_q <= 1'b0;
      funct3_q   <= 3'd0;
      addr_q     <= 32'd0;
      wdata_q    <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      err_q   <= err_d;
      if (accept) begin
        is_store_q <= in_is_store;
        funct3_q   <= in_funct3;
        addr_q     <= in_addr;
        wdata_q    <= in_wdata;
      end
    end
  end

  // Enables are masked by rst so an access cut short by reset never reaches memory.
  always_comb begin
    mem_ren   = 1'b0;
    mem_raddr = 32'd0;
    mem_rlen  = 32'd0;
    mem_wen   = 1'b0;
    mem_waddr = 32'd0;
    mem_wdata = 32'd0;
    mem_wmask = 8'h00;
    if (state_q == StAccess) begin
      if (is_store_q) begin
        mem_wen   = last_access & ~rst;
        mem_waddr = addr_q;
        mem_wdata = wdata_q;
        mem_wmask = wmask;
      end else begin
        mem_ren   = ~rst;
        mem_raddr = addr_q;
        mem_rlen  = len_bytes;
      end
    end
  end

  assign in_ready  = (state_q == StIdle);
  assign out_valid = (state_q == StResp);
  assign out_data  = data_q;
  assign out_err   = err_q;

endmodule

// File: tb/tb_lsu_stage.sv
// Directed bench for lsu_stage: vector table on a zero-wait instance, plus wait-state,
// backpressure and mid-access reset sequences.
module tb_lsu_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_is_store;
  logic [2:0]  in_funct3;
  logic [31:0] in_addr, in_wdata, mem_rdata;
  logic        out_ready;
  logic        in_valid_0, in_valid_3;

  logic        in_ready_0, out_valid_0, out_err_0, mem_ren_0, mem_wen_0;
  logic [31:0] out_data_0, mem_raddr_0, mem_rlen_0, mem_waddr_0, mem_wdata_0;
  logic [7:0]  mem_wmask_0;
  logic        in_ready_3, out_valid_3, out_err_3, mem_ren_3, mem_wen_3;
  logic [31:0] out_data_3, mem_raddr_3, mem_rlen_3, mem_waddr_3, mem_wdata_3;
  logic [7:0]  mem_wmask_3;

  int pass_cnt = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  lsu_stage #(.WAIT_CYCLES(0)) u_dut0 (
    .clk(clk), .rst(rst), .in_valid(in_valid_0), .in_ready(in_ready_0),
    .in_is_store(in_is_store), .in_funct3(in_funct3), .in_addr(in_addr), .in_wdata(in_wdata),
    .out_valid(out_valid_0), .out_ready(out_ready), .out_data(out_data_0), .out_err(out_err_0),
    .mem_ren(mem_ren_0), .mem_raddr(mem_raddr_0), .mem_rlen(mem_rlen_0), .mem_rdata(mem_rdata),
    .mem_wen(mem_wen_0), .mem_waddr(mem_waddr_0), .mem_wdata(mem_wdata_0),
    .mem_wmask(mem_wmask_0)
  );

  lsu_stage #(.WAIT_CYCLES(3)) u_dut3 (
    .clk(clk), .rst(rst), .in_valid(in_valid_3), .in_ready(in_ready_3),
    .in_is_store(in_is_store), .in_funct3(in_funct3), .in_addr(in_addr), .in_wdata(in_wdata),
    .out_valid(out_valid_3), .out_ready(out_ready), .out_data(out_data_3), .out_err(out_err_3),
    .mem_ren(mem_ren_3), .mem_raddr(mem_raddr_3), .mem_rlen(mem_rlen_3), .mem_rdata(mem_rdata),
    .mem_wen(mem_wen_3), .mem_waddr(mem_waddr_3), .mem_wdata(mem_wdata_3),
    .mem_wmask(mem_wmask_3)
  );

  typedef struct {
    logic        st;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        err;
    logic [31:0] data;
    logic [31:0] rlen;
    logic [7:0]  wmask;
  } vec_t;

  vec_t vecs[13];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Accept edge N, access cycle N+1, response cycle N+2, idle again cycle N+3.
  task automatic run_vec(input int i, input vec_t v);
    @(posedge clk); #1;
    chk($sformatf("v%0d in_ready before", i), 32'(in_ready_0), 32'd1);
    in_is_store = v.st;
    in_funct3   = v.f3;
    in_addr     = v.addr;
    in_wdata    = v.wdata;
    mem_rdata   = v.rdata;
    in_valid_0  = 1'b1;
    @(posedge clk); #1;
    in_valid_0 = 1'b0;
    if (v.err) begin
      chk($sformatf("v%0d err out_valid", i), 32'(out_valid_0), 32'd1);
      chk($sformatf("v%0d err out_err", i), 32'(out_err_0), 32'd1);
      chk($sformatf("v%0d err out_data", i), out_data_0, 32'd0);
      chk($sformatf("v%0d err mem_ren", i), 32'(mem_ren_0), 32'd0);
      chk($sformatf("v%0d err mem_wen", i), 32'(mem_wen_0), 32'd0);
    end else begin
      chk($sformatf("v%0d acc out_valid", i), 32'(out_valid_0), 32'd0);
      chk($sformatf("v%0d acc in_ready", i), 32'(in_ready_0), 32'd0);
      chk($sformatf("v%0d mem_ren", i), 32'(mem_ren_0), 32'(!v.st));
      chk($sformatf("v%0d mem_wen", i), 32'(mem_wen_0), 32'(v.st));
      chk($sformatf("v%0d mem_raddr", i), mem_raddr_0, v.st ? 32'd0 : v.addr);
      chk($sformatf("v%0d mem_rlen", i), mem_rlen_0, v.st ? 32'd0 : v.rlen);
      chk($sformatf("v%0d mem_waddr", i), mem_waddr_0, v.st ? v.addr : 32'd0);
      chk($sformatf("v%0d mem_wdata", i), mem_wdata_0, v.st ? v.wdata : 32'd0);
      chk($sformatf("v%0d mem_wmask", i), 32'(mem_wmask_0), v.st ? 32'(v.wmask) : 32'd0);
      @(posedge clk); #1;
      mem_rdata = 32'hA5A5_A5A5;
      chk($sformatf("v%0d resp out_valid", i), 32'(out_valid_0), 32'd1);
      chk($sformatf("v%0d resp out_err", i), 32'(out_err_0), 32'd0);
      chk($sformatf("v%0d resp out_data", i), out_data_0, v.data);
      chk($sformatf("v%0d resp mem_ren", i), 32'(mem_ren_0), 32'd0);
      chk($sformatf("v%0d resp mem_wen", i), 32'(mem_wen_0), 32'd0);
    end
    @(posedge clk); #1;
    chk($sformatf("v%0d in_ready after", i), 32'(in_ready_0), 32'd1);
    chk($sformatf("v%0d out_valid after", i), 32'(out_valid_0), 32'd0);
  endtask

  initial begin
    //          st    f3      addr          wdata         rdata         err   data          rlen wmask
    vecs[0]  = '{1'b0, 3'b000, 32'h8000_0003, 32'h0,        32'h0000_0080, 1'b0, 32'hFFFF_FF80, 1, 8'h00};
    vecs[1]  = '{1'b0, 3'b101, 32'h8000_0002, 32'h0,        32'h0000_BEEF, 1'b0, 32'h0000_BEEF, 2, 8'h00};
    vecs[2]  = '{1'b1, 3'b001, 32'h8000_0004, 32'h1234_5678, 32'h0,        1'b0, 32'h0,         0, 8'h03};
    vecs[3]  = '{1'b0, 3'b010, 32'h8000_0002, 32'h0,        32'hFFFF_FFFF, 1'b1, 32'h0,         0, 8'h00};
    vecs[4]  = '{1'b0, 3'b011, 32'h8000_0000, 32'h0,        32'hFFFF_FFFF, 1'b1, 32'h0,         0, 8'h00};
    vecs[5]  = '{1'b0, 3'b010, 32'h8000_0000, 32'h0,        32'hDEAD_BEEF, 1'b0, 32'hDEAD_BEEF, 4, 8'h00};
    vecs[6]  = '{1'b0, 3'b001, 32'h8000_0006, 32'h0,        32'h0000_8001, 1'b0, 32'hFFFF_8001, 2, 8'h00};
    vecs[7]  = '{1'b0, 3'b100, 32'h8000_0001, 32'h0,        32'hFFFF_FF9A, 1'b0, 32'h0000_009A, 1, 8'h00};
    vecs[8]  = '{1'b0, 3'b000, 32'h8000_0005, 32'h0,        32'h0000_007F, 1'b0, 32'h0000_007F, 1, 8'h00};
    vecs[9]  = '{1'b1, 3'b100, 32'h8000_0000, 32'h55,       32'h0,        1'b1, 32'h0,         0, 8'h00};
    vecs[10] = '{1'b1, 3'b010, 32'h8000_0001, 32'h55,       32'h0,        1'b1, 32'h0,         0, 8'h00};
    vecs[11] = '{1'b1, 3'b000, 32'h8000_0003, 32'h0000_00AB, 32'h0,        1'b0, 32'h0,         0, 8'h01};
    vecs[12] = '{1'b1, 3'b010, 32'h8000_0008, 32'hCAFE_F00D, 32'h0,        1'b0, 32'h0,         0, 8'h0F};

    rst = 1'b1; in_valid_0 = 1'b0; in_valid_3 = 1'b0; in_is_store = 1'b0; in_funct3 = 3'd0;
    in_addr = 32'd0; in_wdata = 32'd0; mem_rdata = 32'd0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst in_ready", 32'(in_ready_0), 32'd1);
    chk("rst out_valid", 32'(out_valid_0), 32'd0);
    chk("rst out_data", out_data_0, 32'd0);
    chk("rst out_err", 32'(out_err_0), 32'd0);
    chk("rst mem_ren", 32'(mem_ren_0), 32'd0);
    chk("rst mem_wen", 32'(mem_wen_0), 32'd0);
    chk("rst mem_rlen", mem_rlen_0, 32'd0);
    chk("rst mem_wmask", 32'(mem_wmask_0), 32'd0);
    rst = 1'b0;

    for (int i = 0; i < 13; i++) run_vec(i, vecs[i]);

    // Four-cycle access with backpressure on the wait-state instance.
    @(posedge clk); #1;
    out_ready = 1'b0; in_is_store = 1'b0; in_funct3 = 3'b010;
    in_addr = 32'h8000_0020; mem_rdata = 32'h1122_3344; in_valid_3 = 1'b1;
    @(posedge clk); #1;
    in_valid_3 = 1'b0;
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("w3 ren c%0d", k), 32'(mem_ren_3), 32'd1);
      chk($sformatf("w3 raddr c%0d", k), mem_raddr_3, 32'h8000_0020);
      chk($sformatf("w3 rlen c%0d", k), mem_rlen_3, 32'd4);
      chk($sformatf("w3 out_valid c%0d", k), 32'(out_valid_3), 32'd0);
      @(posedge clk); #1;
    end
    mem_rdata = 32'hFFFF_0000;
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("w3 hold valid %0d", k), 32'(out_valid_3), 32'd1);
      chk($sformatf("w3 hold data %0d", k), out_data_3, 32'h1122_3344);
      chk($sformatf("w3 hold err %0d", k), 32'(out_err_3), 32'd0);
      chk($sformatf("w3 hold in_ready %0d", k), 32'(in_ready_3), 32'd0);
      chk($sformatf("w3 hold ren %0d", k), 32'(mem_ren_3), 32'd0);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    chk("w3 valid at ready", 32'(out_valid_3), 32'd1);
    chk("w3 data at ready", out_data_3, 32'h1122_3344);
    @(posedge clk); #1;
    chk("w3 in_ready after", 32'(in_ready_3), 32'd1);
    chk("w3 out_valid after", 32'(out_valid_3), 32'd0);

    // Reset landing in the single access cycle of a store must suppress the write.
    @(posedge clk); #1;
    in_is_store = 1'b1; in_funct3 = 3'b010; in_addr = 32'h8000_0010;
    in_wdata = 32'h0BAD_0BAD; in_valid_0 = 1'b1;
    @(posedge clk); #1;
    in_valid_0 = 1'b0;
    rst = 1'b1;
    #1;
    chk("rst-acc mem_wen", 32'(mem_wen_0), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    chk("rst-acc in_ready", 32'(in_ready_0), 32'd1);
    chk("rst-acc out_valid", 32'(out_valid_0), 32'd0);
    chk("rst-acc out_err", 32'(out_err_0), 32'd0);
    chk("rst-acc out_data", out_data_0, 32'd0);
    chk("rst-acc mem_wen idle", 32'(mem_wen_0), 32'd0);
    chk("rst-acc mem_waddr", mem_waddr_0, 32'd0);
    @(posedge clk); #1;
    chk("rst-acc mem_wen later", 32'(mem_wen_0), 32'd0);
    chk("rst-acc out_valid later", 32'(out_valid_0), 32'd0);

    // The stage still works after the aborted store.
    run_vec(13, vecs[5]);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/lsu_stage.md
LSU_STAGE -- requirements
Module: lsu_stage

Interface
REQ-001 Parameter WAIT_CYCLES, default 0: extra cycles the memory request is held before data is sampled (range 0..15).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 in_valid  input  1  EXU presents a memory operation.
REQ-005 in_ready  output  1  stage can accept an operation.
REQ-006 in_is_store  input  1  1 = store, 0 = load.
REQ-007 in_funct3  input  3  RV32 width/sign code (000 B, 001 H, 010 W, 100 BU, 101 HU).
REQ-008 in_addr  input  32  effective byte address.
REQ-009 in_wdata  input  32  store data, right-aligned.
REQ-010 out_valid  output  1  result available to WBU.
REQ-011 out_ready  input  1  WBU accepts result.
REQ-012 out_data  output  32  extended load data; 0 for stores and errors.
REQ-013 out_err  output  1  misaligned or illegal funct3.
REQ-014 mem_ren  output  1  data-read enable to memory port.
REQ-015 mem_raddr  output  32  read address.
REQ-016 mem_rlen  output  32  read length in bytes: 1, 2 or 4.
REQ-017 mem_rdata  input  32  combinational read data, right-aligned, same cycle.
REQ-018 mem_wen  output  1  write enable.
REQ-019 mem_waddr  output  32  write address.
REQ-020 mem_wdata  output  32  write data.
REQ-021 mem_wmask  output  8  byte mask: 8'h01 / 8'h03 / 8'h0F.

Function
REQ-022 States: IDLE, ACCESS, RESP; in_ready = 1 only in IDLE.
REQ-023 IDLE: on in_valid, latch is_store, funct3, addr, wdata; go ACCESS if legal, else RESP with out_err=1.
REQ-024 Legal: loads funct3 in {000,001,010,100,101}; stores in {000,001,010}; H needs addr[0]=0, W needs addr[1:0]=00.
REQ-025 ACCESS: load drives mem_ren=1, mem_raddr=addr, mem_rlen=1/2/4; store drives mem_wen=1, mem_waddr=addr, mem_wdata=wdata, mem_wmask per width.
REQ-026 Wait counter loaded with WAIT_CYCLES on ACCESS entry; ACCESS lasts WAIT_CYCLES+1 cycles; mem outputs held constant throughout.
REQ-027 Store: mem_wen=1 in exactly one cycle (last ACCESS cycle) per store, never repeated.
REQ-028 Load: mem_rdata sampled on last ACCESS cycle; B/H sign-extend from bit 7/15, BU/HU zero-extend, W unchanged; result registered.
REQ-029 Last ACCESS cycle -> RESP; out_valid=1 in RESP only.
REQ-030 RESP: out_data/out_err stable while out_valid && !out_ready; on out_ready go IDLE.
REQ-031 Latency, WAIT_CYCLES=0, out_ready=1: accept edge N, access cycle N+1, out_valid cycle N+2, in_ready cycle N+3.
REQ-032 Error path: no mem_ren/mem_wen ever asserted; out_data=0; out_valid the cycle after accept.
REQ-033 Outside ACCESS: mem_ren=mem_wen=0, mem_raddr/mem_waddr/mem_wdata=0, mem_wmask=0, mem_rlen=0.
REQ-034 in_valid ignored outside IDLE; one operation in flight.

Reset
REQ-035 rst=1 at any state (incl. mid-ACCESS or RESP) -> IDLE next edge; pending op dropped, no write after reset.
REQ-036 Reset values: in_ready=1, out_valid=0, out_data=0, out_err=0, all mem_* = 0, wait counter 0.

Verification
REQ-037 LB addr 0x80000003, mem_rdata 0x00000080 -> mem_rlen=1, out_data 0xFFFFFF80, out_err 0.
REQ-038 LHU addr 0x80000002, mem_rdata 0x0000BEEF -> mem_rlen=2, out_data 0x0000BEEF.
REQ-039 SH addr 0x80000004, wdata 0x12345678 -> one cycle mem_wen=1, waddr 0x80000004, wdata 0x12345678, wmask 8'h03; out_data 0.
REQ-040 LW addr 0x80000002 -> no mem_ren, out_err 1, out_data 0; funct3 011 load -> same.
REQ-041 WAIT_CYCLES=3, LW, out_ready low 2 cycles -> mem_ren high 4 cycles, out_valid held stable until ready, then in_ready.
REQ-042 rst asserted in ACCESS cycle of SW -> mem_wen never 1, next cycle IDLE with reset values.
